// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: returns atan2(y, x) as a binary angle and the
// gain-scaled magnitude, one micro-rotation per clock, one vector in flight.
module cordic_vector #(
   parameter int DATA_W     = 32,
   parameter int ITERATIONS = 30
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     write_vec,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   output logic                     busy,
   output logic                     valid,
   output logic [DATA_W-1:0]        angle_out,
   output logic [DATA_W:0]          mag_out
);

   localparam int XW = DATA_W + 2;
   localparam int CW = $clog2(ITERATIONS + 1);

   typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        iter_q, iter_d;
   logic signed [XW-1:0] x_q, x_d;
   logic signed [XW-1:0] y_q, y_d;
   logic [DATA_W-1:0]    z_q, z_d;
   logic                 zero_q, zero_d;
   logic                 valid_q, valid_d;
   logic [DATA_W-1:0]    angle_q, angle_d;
   logic [DATA_W:0]      mag_q, mag_d;
   logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh;
   logic [DATA_W-1:0]    atan_rom [ITERATIONS];

   // atan(2^-i) in a 32-bit binary angle (2^31 = 180 deg), rounded.
   function automatic logic [31:0] atan32(input int idx);
      case (idx)
         0:  return 32'h2000_0000;
         1:  return 32'h12E4_051E;
         2:  return 32'h09FB_385B;
         3:  return 32'h0511_11D4;
         4:  return 32'h028B_0D43;
         5:  return 32'h0145_D7E1;
         6:  return 32'h00A2_F61E;
         7:  return 32'h0051_7C55;
         8:  return 32'h0028_BE53;
         9:  return 32'h0014_5F2F;
         10: return 32'h000A_2F98;
         11: return 32'h0005_17CC;
         12: return 32'h0002_8BE6;
         13: return 32'h0001_45F3;
         14: return 32'h0000_A2FA;
         15: return 32'h0000_517D;
         16: return 32'h0000_28BE;
         17: return 32'h0000_145F;
         18: return 32'h0000_0A30;
         19: return 32'h0000_0518;
         20: return 32'h0000_028C;
         21: return 32'h0000_0146;
         22: return 32'h0000_00A3;
         23: return 32'h0000_0051;
         24: return 32'h0000_0029;
         25: return 32'h0000_0014;
         26: return 32'h0000_000A;
         27: return 32'h0000_0005;
         28: return 32'h0000_0003;
         29: return 32'h0000_0001;
         30: return 32'h0000_0001;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Rescale the 32-bit table to DATA_W with round-to-nearest on narrowing.
   function automatic logic [DATA_W-1:0] atan_entry(input int idx);
      logic [63:0] wide;
      int          sh;
      wide = {32'd0, atan32(idx)};
      if (DATA_W >= 32) begin
         sh   = DATA_W - 32;
         wide = wide << sh;
      end else begin
         sh   = 32 - DATA_W;
         wide = (wide + (64'd1 << (sh - 1))) >> sh;
      end
      return wide[DATA_W-1:0];
   endfunction

   for (genvar gi = 0; gi < ITERATIONS; gi++) begin : g_rom
      assign atan_rom[gi] = atan_entry(gi);
   end

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      zero_d  = zero_q;
      valid_d = 1'b0;
      angle_d = angle_q;
      mag_d   = mag_q;
      x_ext   = XW'(x_in);
      y_ext   = XW'(y_in);
      x_sh    = x_q >>> iter_q;
      y_sh    = y_q >>> iter_q;

      case (state_q)
         S_IDLE: begin
            if (write_vec) begin
               state_d = S_ROTATE;
               iter_d  = '0;
               // A null vector never moves, so its angle is forced to zero at the end.
               zero_d  = (x_in == '0) && (y_in == '0);
               if (x_in[DATA_W-1]) begin
                  x_d = -x_ext;
                  y_d = -y_ext;
                  z_d = {1'b1, {(DATA_W-1){1'b0}}};
               end else begin
                  x_d = x_ext;
                  y_d = y_ext;
                  z_d = '0;
               end
            end
         end
         S_ROTATE: begin
            if (!y_q[XW-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_rom[iter_q];
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_rom[iter_q];
            end
            iter_d = iter_q + CW'(1);
            if (iter_q == CW'(ITERATIONS - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            angle_d = zero_q ? '0 : z_q;
            mag_d   = x_q[DATA_W:0];
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
         angle_q <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
         angle_q <= angle_d;
         mag_q   <= mag_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign valid     = valid_q;
   assign angle_out = angle_q;
   assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed and random vectors checked against a real-valued
// atan2/magnitude model, plus latency, busy/ignore and mid-operation reset behaviour.
module tb_cordic_vector;

   localparam int    DATA_W = 32;
   localparam int    N      = 30;
   localparam real   PI     = 3.14159265358979323846;
   localparam real   ASCALE = 2147483648.0 / PI;
   localparam real   TWO31  = 2147483648.0;
   localparam real   TWO32  = 4294967296.0;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     write_vec;
   logic signed [DATA_W-1:0] x_in;
   logic signed [DATA_W-1:0] y_in;
   logic                     busy;
   logic                     valid;
   logic [DATA_W-1:0]        angle_out;
   logic [DATA_W:0]          mag_out;

   int  checks   = 0;
   int  failures = 0;
   real k_gain;

   cordic_vector #(.DATA_W(DATA_W), .ITERATIONS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .write_vec (write_vec),
      .x_in      (x_in),
      .y_in      (y_in),
      .busy      (busy),
      .valid     (valid),
      .angle_out (angle_out),
      .mag_out   (mag_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Angle vs. true atan2; the allowance grows as |v| shrinks because input
   // quantisation limits how well a short vector's phase can be resolved.
   task automatic check_angle(input string tag, input logic [DATA_W-1:0] obs, input int x, input int y);
      real v, ea, diff, tol;
      v    = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      ea   = $atan2(real'(y), real'(x)) * ASCALE;
      diff = real'($signed(obs)) - ea;
      if (diff > TWO31) diff = diff - TWO32;
      if (diff < -TWO31) diff = diff + TWO32;
      tol  = 64.0 + 2.0 * N * ASCALE / ((v < 1.0) ? 1.0 : v);
      checks++;
      assert (diff <= tol && diff >= -tol) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0.1f tol=%0.1f", tag, $signed(obs), ea, tol);
      end
   endtask

   task automatic check_mag(input string tag, input logic [DATA_W:0] obs, input int x, input int y);
      real em, diff, tol;
      em   = k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      diff = real'(obs) - em;
      tol  = 4.0 + 1.0e-6 * em + 2.0 * N;
      checks++;
      assert (diff <= tol && diff >= -tol) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0.1f tol=%0.1f", tag, obs, em, tol);
      end
   endtask

   task automatic run_vec(input string tag, input int x, input int y);
      int k;
      @(negedge clk);
      x_in = x; y_in = y; write_vec = 1'b1;
      @(negedge clk);
      write_vec = 1'b0;
      x_in = $urandom; y_in = $urandom;
      check_eq({tag, "_busy"}, longint'(busy), 1);
      k = 0;
      while (valid !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_eq({tag, "_latency"}, k, N + 1);
      check_angle({tag, "_angle"}, angle_out, x, y);
      check_mag({tag, "_mag"}, mag_out, x, y);
      @(negedge clk);
      check_eq({tag, "_valid_one_cycle"}, longint'(valid), 0);
      check_eq({tag, "_busy_clear"}, longint'(busy), 0);
   endtask

   initial begin
      int            vk[$];
      logic [31:0]   va[$];
      logic [32:0]   vm[$];
      int            xr, yr, npulse;

      k_gain = 1.0;
      for (int i = 0; i < N; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

      rst_n = 1'b0; write_vec = 1'b0; x_in = '0; y_in = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", longint'(busy), 0);
      check_eq("rst_valid", longint'(valid), 0);
      check_eq("rst_angle", longint'(angle_out), 0);
      check_eq("rst_mag", longint'(mag_out), 0);
      rst_n = 1'b1;

      run_vec("t1_axis", 10183770, 0);
      run_vec("t2_45deg", 1 << 20, 1 << 20);
      run_vec("t3_180deg", -(1 << 20), 0);
      run_vec("t3_m90deg", 0, -(1 << 20));
      run_vec("t4_min_min", int'(32'h8000_0000), int'(32'h8000_0000));
      run_vec("min_x_axis", int'(32'h8000_0000), 0);
      run_vec("max_max", int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF));
      run_vec("zero_vec", 0, 0);
      check_eq("zero_angle_exact", longint'(angle_out), 0);
      check_eq("zero_mag_exact", longint'(mag_out), 0);

      // Writes at E5 and E31 (DONE) must be ignored; the one at E32 is accepted.
      @(negedge clk);
      x_in = 300000000; y_in = -700000000; write_vec = 1'b1;
      for (int k = 0; k <= 70; k++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            vk.push_back(k); va.push_back(angle_out); vm.push_back(mag_out);
         end
         write_vec = 1'b0;
         if (k == 4)  begin x_in = -1000000000; y_in = 1000000000;  write_vec = 1'b1; end
         if (k == 30) begin x_in = 0;           y_in = -1000000000; write_vec = 1'b1; end
         if (k == 31) begin x_in = 123456789;   y_in = 987654321;   write_vec = 1'b1; end
      end
      npulse = vk.size();
      check_eq("ign_pulse_count", npulse, 2);
      check_eq("ign_first_at", (npulse > 0) ? vk[0] : -1, N + 1);
      check_eq("ign_second_at", (npulse > 1) ? vk[1] : -1, 2 * N + 3);
      check_angle("ign_first_angle", (npulse > 0) ? va[0] : 32'h0, 300000000, -700000000);
      check_mag("ign_first_mag", (npulse > 0) ? vm[0] : 33'h0, 300000000, -700000000);
      check_angle("acc_second_angle", (npulse > 1) ? va[1] : 32'h0, 123456789, 987654321);
      check_mag("acc_second_mag", (npulse > 1) ? vm[1] : 33'h0, 123456789, 987654321);

      // Asynchronous reset at E10 of an operation aborts it.
      @(negedge clk);
      x_in = 700000000; y_in = 500000000; write_vec = 1'b1;
      @(negedge clk);
      write_vec = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", longint'(busy), 0);
      check_eq("mid_rst_valid", longint'(valid), 0);
      check_eq("mid_rst_angle", longint'(angle_out), 0);
      check_eq("mid_rst_mag", longint'(mag_out), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      npulse = 0;
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         if (valid === 1'b1) npulse++;
      end
      check_eq("mid_rst_no_valid", npulse, 0);
      run_vec("post_rst_90deg", 0, 1 << 20);

      for (int r = 0; r < 24; r++) begin
         xr = int'($urandom) >>> $urandom_range(0, 8);
         yr = int'($urandom) >>> $urandom_range(0, 8);
         run_vec($sformatf("rand%0d", r), xr, yr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
